// File: rtl/modular_multiplier.sv
// Bit-serial modular multiplier: out = (a*b) mod p.
// Scans b from MSB down with double-and-add, one bit per clock.
module modular_multiplier #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] out,
  output logic             Done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IW-1:0]    i_q, i_d;

  logic [WIDTH+1:0] p_x;
  logic [WIDTH+1:0] dbl;
  logic [WIDTH+1:0] dbl_red;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_red;

  // Two extra bits keep 2R and 2R-p+a exact before each compare.
  always_comb begin
    p_x     = {2'b00, p_q};
    dbl     = {1'b0, r_q, 1'b0};
    dbl_red = (dbl >= p_x) ? dbl - p_x : dbl;
    acc     = b_q[i_q] ? dbl_red + {2'b00, a_q} : dbl_red;
    acc_red = (acc >= p_x) ? acc - p_x : acc;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    r_d     = r_q;
    i_d     = i_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = a;
          b_d     = b;
          p_d     = p;
          r_d     = '0;
          i_d     = IW'(WIDTH - 1);
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        r_d = WIDTH'(acc_red);
        i_d = i_q - IW'(1);
        if (i_q == '0) state_d = FINISH;
      end
      FINISH: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      i_q     <= i_d;
    end
  end

  // Outputs are masked while Reset is high, even before the reset edge.
  assign Done = (state_q == FINISH) && !Reset;
  assign out  = Done ? r_q : '0;

endmodule

// File: tb/tb_modular_multiplier.sv
// Directed-vector bench for modular_multiplier at WIDTH=256.
// Each scenario task checks its own results inline.
module tb_modular_multiplier;

  localparam int W   = 256;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic [W-1:0] out;
  logic         Done;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] p25519;
  logic [W-1:0] two254;

  always #5 clk = ~clk;

  modular_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Start (Start),
    .a     (a),
    .b     (b),
    .p     (p),
    .out   (out),
    .Done  (Done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation; lat counts edges from the Start edge
  // (inclusive) until Done is seen.
  task automatic do_op(
    input  logic [W-1:0] ta,
    input  logic [W-1:0] tb,
    input  logic [W-1:0] tp,
    input  bit           hold,
    input  bit           scramble,
    output int           lat,
    output bit           quiet,
    output logic [W-1:0] res
  );
    a     = ta;
    b     = tb;
    p     = tp;
    Start = 1'b1;
    tick();
    lat   = 1;
    quiet = 1'b1;
    if (!hold) Start = 1'b0;
    while (Done !== 1'b1 && lat < LAT + 40) begin
      if (out !== '0 || Done !== 1'b0) quiet = 1'b0;
      if (scramble) begin
        a = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      lat++;
    end
    res = out;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    a = 3; b = 5; p = 7;
    repeat (3) tick();
    vectors++;
    if (Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got=%b want=0", Done);
    end
    vectors++;
    if (out !== '0) begin
      miscompares++;
      $display("FAIL reset_out got=%h want=0", out);
    end
    Reset = 1'b0;
    Start = 1'b0;
    repeat (LAT + 5) tick();
    vectors++;
    if (Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_start got=%b want=0", Done);
    end
  endtask

  task automatic test_basic();
    int lat; bit quiet; logic [W-1:0] res;
    do_op(3, 5, 7, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
    end
    vectors++;
    if (res !== W'(1)) begin
      miscompares++;
      $display("FAIL basic_out got=%h want=1", res);
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL basic_quiet got=active want=zero_before_finish");
    end
    tick();
    vectors++;
    if (Done !== 1'b0 || out !== '0) begin
      miscompares++;
      $display("FAIL basic_back_idle got=%b/%h want=0/0", Done, out);
    end
  endtask

  task automatic test_small();
    logic [W-1:0] ta [4] = '{W'(4), W'(6), W'(10), W'(12)};
    logic [W-1:0] tb [4] = '{W'(5), W'(6), W'(10), W'(7)};
    logic [W-1:0] tp [4] = '{W'(13), W'(7), W'(11), W'(17)};
    logic [W-1:0] ex [4] = '{W'(7), W'(1), W'(1), W'(16)};
    for (int k = 0; k < 4; k++) begin
      int lat; bit quiet; logic [W-1:0] res;
      do_op(ta[k], tb[k], tp[k], 1'b0, 1'b0, lat, quiet, res);
      vectors++;
      if (res !== ex[k] || lat !== LAT) begin
        miscompares++;
        $display("FAIL small_%0d got=%0d lat=%0d want=%0d lat=%0d",
                 k, res, lat, ex[k], LAT);
      end
      tick();
    end
  endtask

  task automatic test_curve();
    int lat; bit quiet; logic [W-1:0] res;
    do_op(p25519 - 1, p25519 - 1, p25519, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(1)) begin
      miscompares++;
      $display("FAIL curve_sq got=%h want=1", res);
    end
    tick();
    do_op(2, two254, p25519, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(19) || lat !== LAT) begin
      miscompares++;
      $display("FAIL curve_wrap got=%h lat=%0d want=13 lat=%0d",
               res, lat, LAT);
    end
    tick();
  endtask

  task automatic test_identity();
    int lat; bit quiet; logic [W-1:0] res;
    do_op(0, p25519 - 1, p25519, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== '0 || lat !== LAT || !quiet) begin
      miscompares++;
      $display("FAIL zero_mul got=%h lat=%0d quiet=%b want=0 lat=%0d quiet=1",
               res, lat, quiet, LAT);
    end
    tick();
    do_op(12345, 1, p25519, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(12345)) begin
      miscompares++;
      $display("FAIL one_mul got=%0d want=12345", res);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; bit quiet; logic [W-1:0] res;
    a = 3; b = 5; p = 7;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (100) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if (Done !== 1'b0 || out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got=%b/%h want=0/0", Done, out);
    end
    do_op(3, 5, 7, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(1) || lat !== LAT) begin
      miscompares++;
      $display("FAIL after_reset got=%h lat=%0d want=1 lat=%0d",
               res, lat, LAT);
    end
    tick();
  endtask

  task automatic test_hold();
    int lat; bit quiet; logic [W-1:0] res; bit ok;
    do_op(4, 5, 13, 1'b1, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(7) || lat !== LAT) begin
      miscompares++;
      $display("FAIL hold_op got=%0d lat=%0d want=7 lat=%0d", res, lat, LAT);
    end
    ok = 1'b1;
    a = 6; b = 6;
    repeat (LAT + 3) begin
      tick();
      if (Done !== 1'b1 || out !== W'(7)) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_stay got=%b/%0d want=1/7", Done, out);
    end
    Start = 1'b0;
    tick();
    vectors++;
    if (Done !== 1'b0 || out !== '0) begin
      miscompares++;
      $display("FAIL hold_release got=%b/%h want=0/0", Done, out);
    end
    do_op(4, 5, 13, 1'b1, 1'b0, lat, quiet, res);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    vectors++;
    if (Done !== 1'b0 || out !== '0) begin
      miscompares++;
      $display("FAIL reset_finish got=%b/%h want=0/0", Done, out);
    end
  endtask

  task automatic test_isolation();
    int lat; bit quiet; logic [W-1:0] res;
    do_op(2, two254, p25519, 1'b0, 1'b1, lat, quiet, res);
    vectors++;
    if (res !== W'(19) || lat !== LAT) begin
      miscompares++;
      $display("FAIL isolation got=%h lat=%0d want=13 lat=%0d",
               res, lat, LAT);
    end
    tick();
    do_op(10, 10, 11, 1'b0, 1'b0, lat, quiet, res);
    vectors++;
    if (res !== W'(1) || lat !== LAT) begin
      miscompares++;
      $display("FAIL back_to_back got=%0d lat=%0d want=1 lat=%0d",
               res, lat, LAT);
    end
    tick();
  endtask

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    a      = '0;
    b      = '0;
    p      = '0;
    p25519 = (W'(1) << 255) - W'(19);
    two254 = W'(1) << 254;
    tick();
    test_reset();
    test_basic();
    test_small();
    test_curve();
    test_identity();
    test_reset_mid();
    test_hold();
    test_isolation();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
